dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data RAM between the CPU data port (port 0) and a second bus master such as a loader or DMA engine (port 1). It sits between the requesters and the RAM's `addr`/`wval`/`we`/`rval` interface. It grants one access per cycle with round-robin fairness and an optional bounded lock for bursts. Read data is returned registered, one cycle after the access.

## Interface

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_HOLD, 4, maximum consecutive locked grants to one port (≥1)

Ports (reset is synchronous, active-high; clock and reset first):
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- p0_req  in  1  port 0 access request; held with addr/we/wval until ack
- p0_we  in  1  port 0 write enable (1 write, 0 read)
- p0_lock  in  1  port 0 requests to keep the grant for the next access
- p0_addr  in  AW  port 0 address
- p0_wval  in  DW  port 0 write data
- p0_ack  out  1  port 0 access performed this cycle
- p0_rval  out  DW  port 0 read data, valid when p0_rvalid
- p0_rvalid  out  1  port 0 read data valid (one cycle after a read ack)
- p1_req, p1_we, p1_lock, p1_addr, p1_wval, p1_ack, p1_rval, p1_rvalid: same as port 0, for port 1
- mem_addr  out  AW  RAM address
- mem_wval  out  DW  RAM write data
- mem_we  out  1  RAM write enable; RAM writes on the clock edge ending the cycle
- mem_rval  in  DW  RAM combinational read data for mem_addr

## Operation

- FSM states: IDLE, GNT0, GNT1 (registered). A round-robin pointer `rr` names the port that has priority on the next contention. A hold counter `hold` (width clog2(MAX_HOLD)+1) counts consecutive locked grants.
- IDLE: RAM outputs are 0 and mem_we=0; no ack. Next state:
  - only pX_req → GNTx;
  - both requesting → GNT[rr];
  - none → IDLE.
- GNTx: mem_addr/mem_wval are taken from port x and mem_we = pX_req & pX_we. pX_ack = pX_req (combinational from state and req); the other port's ack = 0.
- Next state from GNTx, evaluated in the same cycle:
  - pX_req & pX_lock & hold < MAX_HOLD-1 → stay in GNTx, hold++;
  - else if other port requesting → GNT(other), hold=0;
  - else if pX_req → stay in GNTx, hold=0;
  - else → IDLE, hold=0.
- rr update: whenever an ack is issued to port x, rr ← other port.
- Read return: on pX_ack & !pX_we, register pX_rval ← mem_rval and set pX_rvalid=1 for exactly one cycle. Otherwise pX_rvalid=0 and pX_rval holds its last value.
- Requester rule: once req is asserted, keep it and the attributes stable until ack. If req is dropped while the port is in its GNT state: no ack, no write, and the next state follows the table above.
- Never: both acks in one cycle, or mem_we=1 without a corresponding ack.

## Timing

- Reset (synchronous, dominates everything): state=IDLE, rr=0, hold=0, pX_rvalid=0, pX_rval=0. During and after reset, until a grant: mem_we=0, mem_addr=0, mem_wval=0, acks=0. A reset asserted mid-burst aborts the access: no write occurs on that edge.
- Latency from IDLE: req rising in cycle N → ack in cycle N+1. Read data valid in cycle N+2.
- Streaming: a requester already granted with no competition gets an ack every cycle. Read data follows at 1/cycle, one cycle behind the acks.
- Contention without lock: acks alternate port-by-port every cycle.
- Lock: at most MAX_HOLD consecutive acks to one port while the other requests. The other port is then guaranteed the next cycle.
- Simultaneous first requests from IDLE after reset: port 0 wins (rr=0).

## Test plan

- Reset with p0_req=1 held → all acks 0, mem_we 0, rvalid 0 during reset. First cycle after reset: state GNT0 next, so p0_ack=1 in the second post-reset cycle.
- Port 0 write 0xDEADBEEF to addr 0x10, then read 0x10 → write ack with mem_we=1 and correct addr/data. Read ack one cycle later with mem_we=0, then p0_rvalid=1 and p0_rval=0xDEADBEEF.
- Both ports continuously requesting reads, no lock → acks alternate 0,1,0,1… Each rvalid pulse follows its own ack by one cycle with that port's data.
- p1_lock=1 streaming, p0 requesting, MAX_HOLD=4 → exactly 4 consecutive p1 acks, then p0_ack. rr then favours p1 on the next contention.
- p0 drops req while in GNT0 with p1 idle → no ack, mem_we=0, return to IDLE. A later p1_req gets p1_ack one cycle after assertion.
- Reset asserted in the cycle of a granted write → mem_we=0 that cycle. RAM content at that address is unchanged (check by a read after reset).

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle between the two data-RAM requesters, the RAM and the arbiter.
// The arbiter uses the slave view; the requesters and RAM together use the master view.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          p0_req;
    logic          p0_we;
    logic          p0_lock;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wval;
    logic          p0_ack;
    logic [DW-1:0] p0_rval;
    logic          p0_rvalid;

    logic          p1_req;
    logic          p1_we;
    logic          p1_lock;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wval;
    logic          p1_ack;
    logic [DW-1:0] p1_rval;
    logic          p1_rvalid;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wval;
    logic          mem_we;
    logic [DW-1:0] mem_rval;

    modport slave (
        input  p0_req, p0_we, p0_lock, p0_addr, p0_wval,
        input  p1_req, p1_we, p1_lock, p1_addr, p1_wval,
        input  mem_rval,
        output p0_ack, p0_rval, p0_rvalid,
        output p1_ack, p1_rval, p1_rvalid,
        output mem_addr, mem_wval, mem_we
    );

    modport master (
        output p0_req, p0_we, p0_lock, p0_addr, p0_wval,
        output p1_req, p1_we, p1_lock, p1_addr, p1_wval,
        output mem_rval,
        input  p0_ack, p0_rval, p0_rvalid,
        input  p1_ack, p1_rval, p1_rvalid,
        input  mem_addr, mem_wval, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data RAM between the CPU port and a second master.
// One access per cycle, bounded burst lock, registered read return.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          rr;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nxt;

    logic          sel1;
    logic          own_req;
    logic          own_we;
    logic          own_lock;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wval;
    logic          other_req;

    logic          ack0;
    logic          ack1;
    logic          we_out;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] wval_out;

    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rval0;
    logic [DW-1:0] rval1;

    assign sel1      = (state == GNT1);
    assign own_req   = sel1 ? bus.p1_req  : bus.p0_req;
    assign own_we    = sel1 ? bus.p1_we   : bus.p0_we;
    assign own_lock  = sel1 ? bus.p1_lock : bus.p0_lock;
    assign own_addr  = sel1 ? bus.p1_addr : bus.p0_addr;
    assign own_wval  = sel1 ? bus.p1_wval : bus.p0_wval;
    assign other_req = sel1 ? bus.p0_req  : bus.p1_req;

    always_comb begin
        state_nxt = state;
        hold_nxt  = '0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        we_out    = 1'b0;
        addr_out  = '0;
        wval_out  = '0;
        unique case (state)
            IDLE: begin
                if (bus.p0_req && bus.p1_req)
                    state_nxt = rr ? GNT1 : GNT0;
                else if (bus.p0_req)
                    state_nxt = GNT0;
                else if (bus.p1_req)
                    state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                addr_out = own_addr;
                wval_out = own_wval;
                we_out   = own_req & own_we;
                ack0     = ~sel1 & own_req;
                ack1     = sel1 & own_req;
                if (own_req && own_lock && hold < HOLD_LAST)
                    hold_nxt = hold + HW'(1);
                else if (other_req)
                    state_nxt = sel1 ? GNT0 : GNT1;
                else if (!own_req)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // a reset landing mid-access must not let the RAM write on that edge
        if (reset) begin
            ack0     = 1'b0;
            ack1     = 1'b0;
            we_out   = 1'b0;
            addr_out = '0;
            wval_out = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            rr      <= 1'b0;
            hold    <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rval0   <= '0;
            rval1   <= '0;
        end else begin
            state   <= state_nxt;
            hold    <= hold_nxt;
            if (ack0)
                rr <= 1'b1;
            else if (ack1)
                rr <= 1'b0;
            rvalid0 <= ack0 & ~bus.p0_we;
            rvalid1 <= ack1 & ~bus.p1_we;
            if (ack0 && !bus.p0_we)
                rval0 <= bus.mem_rval;
            if (ack1 && !bus.p1_we)
                rval1 <= bus.mem_rval;
        end
    end

    assign bus.p0_ack    = ack0;
    assign bus.p1_ack    = ack1;
    assign bus.p0_rval   = rval0;
    assign bus.p1_rval   = rval1;
    assign bus.p0_rvalid = rvalid0;
    assign bus.p1_rvalid = rvalid1;
    assign bus.mem_addr  = addr_out;
    assign bus.mem_wval  = wval_out;
    assign bus.mem_we    = we_out;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized two-port traffic,
// checked by a per-port scoreboard against a shadow copy of the RAM.
module tb_dmem_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wval;
    } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 32'h0001_0203) ^ 32'hA5A5_0000;
    endfunction

    // RAM: combinational read, write on the clock edge ending the cycle
    logic [DW-1:0] ram [256];
    bit            written [256];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            ram[bus.mem_addr[7:0]]     <= bus.mem_wval;
            written[bus.mem_addr[7:0]] <= 1'b1;
        end
    end

    assign bus.mem_rval = written[bus.mem_addr[7:0]] ? ram[bus.mem_addr[7:0]]
                                                     : init_val(int'(bus.mem_addr[7:0]));

    logic [DW-1:0] shadow [256];
    acc_t          acc_q0[$];
    acc_t          acc_q1[$];
    logic [DW-1:0] rd_q0[$];
    logic [DW-1:0] rd_q1[$];
    int            ack_seq[$];
    bit            rec = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int info);
        total++;
        bad++;
        $display("FAIL %s: info %0d", name, info);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic set_port(input int p, input logic we, input logic lock,
                            input logic [7:0] a, input logic [DW-1:0] wv);
        if (p == 0) begin
            bus.p0_we   = we;
            bus.p0_lock = lock;
            bus.p0_addr = AW'(a);
            bus.p0_wval = wv;
            bus.p0_req  = 1'b1;
        end else begin
            bus.p1_we   = we;
            bus.p1_lock = lock;
            bus.p1_addr = AW'(a);
            bus.p1_wval = wv;
            bus.p1_req  = 1'b1;
        end
    endtask

    task automatic drop_port(input int p);
        if (p == 0) begin
            bus.p0_req  = 1'b0;
            bus.p0_lock = 1'b0;
        end else begin
            bus.p1_req  = 1'b0;
            bus.p1_lock = 1'b0;
        end
    endtask

    // expected effect of one access, known at issue time from the shadow RAM
    task automatic expect_acc(input int p, input logic we,
                              input logic [7:0] a, input logic [DW-1:0] wv);
        acc_t e;
        e.we   = we;
        e.addr = AW'(a);
        e.wval = wv;
        if (p == 0) acc_q0.push_back(e);
        else        acc_q1.push_back(e);
        if (we) shadow[a] = wv;
        else if (p == 0) rd_q0.push_back(shadow[a]);
        else rd_q1.push_back(shadow[a]);
    endtask

    task automatic drive(input int p, input logic we, input logic lock,
                         input logic [7:0] a, input logic [DW-1:0] wv, output int waited);
        expect_acc(p, we, a, wv);
        set_port(p, we, lock, a, wv);
        waited = 0;
        forever begin
            @(negedge clk);
            if ((p == 0) ? bus.p0_ack : bus.p1_ack) break;
            if (waited >= 50) begin
                fail("ack_timeout", p);
                break;
            end
            tick();
            waited++;
        end
        tick();
        drop_port(p);
    endtask

    // monitor: scoreboard pops, read-return timing, exclusivity and hold bound
    logic pend0 = 1'b0;
    logic pend1 = 1'b0;
    int   run = 0;
    int   last_port = -1;
    int   last_cyc = -10;
    int   cyc = 0;

    always @(negedge clk) begin : mon
        acc_t e;
        int   r;
        check("p0_rvalid_timing", 64'(bus.p0_rvalid), 64'(pend0));
        check("p1_rvalid_timing", 64'(bus.p1_rvalid), 64'(pend1));
        if (bus.p0_rvalid) begin
            if (rd_q0.size() == 0) fail("p0_unexpected_rvalid", cyc);
            else check("p0_rval", 64'(bus.p0_rval), 64'(rd_q0.pop_front()));
        end
        if (bus.p1_rvalid) begin
            if (rd_q1.size() == 0) fail("p1_unexpected_rvalid", cyc);
            else check("p1_rval", 64'(bus.p1_rval), 64'(rd_q1.pop_front()));
        end
        check("single_ack", 64'(bus.p0_ack & bus.p1_ack), 64'(0));
        if (bus.mem_we && !(bus.p0_ack || bus.p1_ack))
            fail("we_without_ack", cyc);
        if (rst) begin
            check("rst_ctrl", 64'({bus.p0_ack, bus.p1_ack, bus.mem_we}), 64'(0));
            check("rst_addr", 64'(bus.mem_addr), 64'(0));
            check("rst_wval", 64'(bus.mem_wval), 64'(0));
        end
        if (bus.p0_ack) begin
            if (acc_q0.size() == 0) fail("p0_unexpected_ack", cyc);
            else begin
                e = acc_q0.pop_front();
                check("p0_mem_addr", 64'(bus.mem_addr), 64'(e.addr));
                check("p0_mem_we", 64'(bus.mem_we), 64'(e.we));
                if (e.we) check("p0_mem_wval", 64'(bus.mem_wval), 64'(e.wval));
            end
        end
        if (bus.p1_ack) begin
            if (acc_q1.size() == 0) fail("p1_unexpected_ack", cyc);
            else begin
                e = acc_q1.pop_front();
                check("p1_mem_addr", 64'(bus.mem_addr), 64'(e.addr));
                check("p1_mem_we", 64'(bus.mem_we), 64'(e.we));
                if (e.we) check("p1_mem_wval", 64'(bus.mem_wval), 64'(e.wval));
            end
        end
        if (bus.p0_ack || bus.p1_ack) begin
            r = bus.p1_ack ? 1 : 0;
            if (rec) ack_seq.push_back(r);
            if ((bus.p0_ack && bus.p1_req) || (bus.p1_ack && bus.p0_req)) begin
                r = (last_port == r && last_cyc == cyc - 1) ? run + 1 : 1;
                check("hold_bound", 64'(r <= MAX_HOLD), 64'(1));
                run <= r;
            end else begin
                run <= 0;
            end
            last_port <= bus.p1_ack ? 1 : 0;
            last_cyc  <= cyc;
        end
        pend0 <= bus.p0_ack & ~bus.p0_we;
        pend1 <= bus.p1_ack & ~bus.p1_we;
        cyc   <= cyc + 1;
    end

    int exp_lock [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};

    initial begin
        int w0;
        int w1;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_lock = 1'b0;
        bus.p0_addr = '0; bus.p0_wval = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_lock = 1'b0;
        bus.p1_addr = '0; bus.p1_wval = '0;

        // p0 read held through reset: ack only in the second post-reset cycle
        expect_acc(0, 1'b0, 8'h10, '0);
        set_port(0, 1'b0, 1'b0, 8'h10, '0);
        repeat (3) begin
            @(negedge clk);
            check("rst_p0_ack", 64'(bus.p0_ack), 64'(0));
            check("rst_p0_rvalid", 64'(bus.p0_rvalid), 64'(0));
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ack_c1", 64'(bus.p0_ack), 64'(0));
        check("post_rst_rval", 64'(bus.p0_rval), 64'(0));
        tick();
        @(negedge clk);
        check("post_rst_ack_c2", 64'(bus.p0_ack), 64'(1));
        tick();
        drop_port(0);
        idle(3);

        // write then streamed read of the same word
        drive(0, 1'b1, 1'b0, 8'h10, 32'hDEAD_BEEF, w0);
        check("lat_from_idle", 64'(w0), 64'(1));
        drive(0, 1'b0, 1'b0, 8'h10, '0, w0);
        check("lat_streaming", 64'(w0), 64'(0));
        @(negedge clk);
        check("beef_rvalid", 64'(bus.p0_rvalid), 64'(1));
        check("beef_rval", 64'(bus.p0_rval), 64'(32'hDEAD_BEEF));
        idle(3);

        // unlocked contention: strict alternation, port 1 first (last ack was port 0)
        ack_seq.delete();
        rec = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    drive(0, 1'b0, 1'b0, 8'($urandom_range(0, 127)), '0, w0);
            end
            begin
                for (int i = 0; i < 6; i++)
                    drive(1, 1'b0, 1'b0, 8'($urandom_range(128, 255)), '0, w1);
            end
        join
        rec = 1'b0;
        check("alt_count", 64'(ack_seq.size()), 64'(12));
        if (ack_seq.size() > 0) check("alt_first", 64'(ack_seq[0]), 64'(1));
        for (int i = 1; i < ack_seq.size(); i++)
            check("alt_toggle", 64'(ack_seq[i] != ack_seq[i-1]), 64'(1));
        idle(3);

        // p1 locked burst, p0 joins two cycles in: 4 p1 acks, then p0
        ack_seq.delete();
        rec = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive(1, 1'b0, 1'b1, 8'(128 + i), '0, w1);
            end
            begin
                idle(2);
                drive(0, 1'b0, 1'b0, 8'h05, '0, w0);
            end
        join
        rec = 1'b0;
        check("lock_count", 64'(ack_seq.size()), 64'(9));
        for (int i = 0; i < 9 && i < ack_seq.size(); i++)
            check("lock_seq", 64'(ack_seq[i]), 64'(exp_lock[i]));
        idle(3);

        // after a p0 ack the pointer favours p1 on the next contention
        drive(0, 1'b0, 1'b0, 8'h06, '0, w0);
        idle(3);
        ack_seq.delete();
        rec = 1'b1;
        fork
            drive(0, 1'b0, 1'b0, 8'h07, '0, w0);
            drive(1, 1'b0, 1'b0, 8'h87, '0, w1);
        join
        rec = 1'b0;
        check("rr_count", 64'(ack_seq.size()), 64'(2));
        if (ack_seq.size() > 0) check("rr_first", 64'(ack_seq[0]), 64'(1));
        idle(3);

        // p0 abandons its request while granted
        set_port(0, 1'b1, 1'b0, 8'h40, 32'h0BAD_F00D);
        tick();
        bus.p0_req = 1'b0;
        @(negedge clk);
        check("drop_ack", 64'(bus.p0_ack), 64'(0));
        check("drop_we", 64'(bus.mem_we), 64'(0));
        tick();
        @(negedge clk);
        check("drop_idle_addr", 64'(bus.mem_addr), 64'(0));
        tick();
        drive(1, 1'b0, 1'b0, 8'hC0, '0, w1);
        check("drop_p1_lat", 64'(w1), 64'(1));
        idle(3);

        // reset lands in the cycle of a granted write
        set_port(0, 1'b1, 1'b0, 8'h20, 32'h1234_5678);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_wr_ack", 64'(bus.p0_ack), 64'(0));
        check("rst_wr_we", 64'(bus.mem_we), 64'(0));
        tick();
        drop_port(0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst2_rvalid", 64'(bus.p0_rvalid), 64'(0));
        check("rst2_rval", 64'(bus.p0_rval), 64'(0));
        tick();
        drive(0, 1'b0, 1'b0, 8'h20, '0, w0);
        @(negedge clk);
        check("rst_no_write", 64'(bus.p0_rval), 64'(init_val(32)));
        idle(3);

        // random mixed traffic, each port in its own address half
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    idle($urandom_range(0, 2));
                    drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 127)), $urandom, w0);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    idle($urandom_range(0, 2));
                    drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(128, 255)), $urandom, w1);
                end
            end
        join
        idle(4);
        check("queues_drained",
              64'(acc_q0.size() + acc_q1.size() + rd_q0.size() + rd_q1.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
